fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the RISC-V core.
- Owns the fetch PC and issues word reads to the instruction memory, which has 1-cycle read latency.
- Buffers returned instructions in a small fetch queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects, decode back-pressure and misaligned-target traps, replacing ad-hoc stall/NOP injection at the memory.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-sequencer port bundle: instruction-memory read port, redirect input,
// decode valid/ready port and misaligned-target trap outputs.
interface fetch_ctrl_if #(
   parameter int PC_WIDTH = 32
);
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic [31:0]         imem_rdata;
   logic                redir_valid;
   logic [PC_WIDTH-1:0] redir_pc;
   logic                dec_valid;
   logic                dec_ready;
   logic [31:0]         dec_inst;
   logic [PC_WIDTH-1:0] dec_pc;
   logic                misalign;
   logic [PC_WIDTH-1:0] misalign_pc;

   modport master (
      output imem_req, imem_addr, dec_valid, dec_inst, dec_pc, misalign, misalign_pc,
      input  imem_rdata, redir_valid, redir_pc, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_inst, dec_pc, misalign, misalign_pc,
      output imem_rdata, redir_valid, redir_pc, dec_ready
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: request in cycle C reaches decode in C+2, 1 inst/cycle steady state.
// Decode back-pressure stops new requests once queue plus in-flight would exceed FQ_DEPTH.
module fetch_ctrl #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter logic [31:0]         NOP_INST = 32'h00000033,
   parameter int                  FQ_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   fetch_ctrl_if.master  fif
);
   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] TRAP = 1'b1;

   logic [0:0]          state;
   logic [PC_WIDTH-1:0] fpc;
   logic                inflight;
   logic [PC_WIDTH-1:0] inflight_pc;
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;
   logic [CW-1:0]       count;
   logic [PC_WIDTH-1:0] misalign_pc;

   logic [31:0]         q_inst [FQ_DEPTH];
   logic [PC_WIDTH-1:0] q_pc   [FQ_DEPTH];

   logic                dec_valid;
   logic                pop;
   logic                req;
   logic [CW:0]         occ;
   logic [CW:0]         lim;

   assign dec_valid = (count != '0);
   assign pop       = dec_valid & fif.dec_ready;

   // A slot freed by this cycle's pop may be reused by this cycle's request.
   assign occ = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign lim = (CW+1)'(FQ_DEPTH) + {{CW{1'b0}}, pop};
   assign req = !rst && !fif.redir_valid && (state == RUN) && (occ < lim);

   assign fif.imem_req    = req;
   assign fif.imem_addr   = fpc;
   assign fif.dec_valid   = dec_valid;
   assign fif.dec_inst    = dec_valid ? q_inst[rd_ptr] : NOP_INST;
   assign fif.dec_pc      = dec_valid ? q_pc[rd_ptr]   : '0;
   assign fif.misalign    = (state == TRAP);
   assign fif.misalign_pc = misalign_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         fpc         <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         misalign_pc <= '0;
      end else if (fif.redir_valid) begin
         // Flush wins over any pop or response arriving this cycle.
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
         if (fif.redir_pc[1:0] == 2'b00) begin
            state <= RUN;
            fpc   <= fif.redir_pc;
         end else begin
            state       <= TRAP;
            misalign_pc <= fif.redir_pc;
         end
      end else begin
         if (inflight) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count    <= count + CW'(inflight) - CW'(pop);
         inflight <= req;
         if (req) begin
            fpc         <= fpc + PC_WIDTH'(4);
            inflight_pc <= fpc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !fif.redir_valid && inflight) begin
         q_inst[wr_ptr] <= fif.imem_rdata;
         q_pc[wr_ptr]   <= inflight_pc;
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stream, stall, redirect, trap, reset-with-redirect and PC wrap.
module tb_fetch_ctrl;
   localparam logic [31:0] NOP = 32'h00000033;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   fetch_ctrl_if #(.PC_WIDTH(32)) fif ();

   fetch_ctrl #(
      .PC_WIDTH (32),
      .RESET_PC (32'h00000000),
      .NOP_INST (NOP),
      .FQ_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif)
   );

   // Memory image: word k holds k + 0x100.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) + 32'h100;
   endfunction

   // One-cycle-latency memory; unrequested cycles return junk so stray enqueues show up.
   always @(posedge clk)
      fif.imem_rdata <= fif.imem_req ? mem_word(fif.imem_addr) : 32'hDEADBEEF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic nxt(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
      @(posedge clk);
      #1;
      cyc++;
      rst             = r;
      fif.redir_valid = rv;
      fif.redir_pc    = rpc;
      fif.dec_ready   = rdy;
      #1;
   endtask

   task automatic exp_cyc(input logic req, input logic [31:0] addr, input logic vld, input logic [31:0] pc);
      chk("imem_req", {31'b0, fif.imem_req}, {31'b0, req});
      if (req) chk("imem_addr", fif.imem_addr, addr);
      chk("dec_valid", {31'b0, fif.dec_valid}, {31'b0, vld});
      chk("dec_inst", fif.dec_inst, vld ? mem_word(pc) : NOP);
      if (vld) chk("dec_pc", fif.dec_pc, pc);
   endtask

   task automatic exp_trap(input logic m, input logic [31:0] mpc);
      chk("misalign", {31'b0, fif.misalign}, {31'b0, m});
      chk("misalign_pc", fif.misalign_pc, mpc);
   endtask

   initial begin
      fif.redir_valid = 1'b0;
      fif.redir_pc    = '0;
      fif.dec_ready   = 1'b1;

      // Reset state
      nxt(1, 0, 0, 1);
      nxt(1, 0, 0, 1);
      exp_cyc(0, 0, 0, 0);
      chk("rst dec_pc", fif.dec_pc, 32'h0);
      exp_trap(0, 0);
      cyc = 0;

      // Stream from RESET_PC: requests at cycles 1.., data from cycle 3
      for (int c = 1; c <= 6; c++) begin
         nxt(0, 0, 0, 1);
         exp_cyc(1, 32'(4 * (c - 1)), (c >= 3), 32'(4 * (c - 3)));
      end

      // Decode stall for 5 cycles: queue fills to 2, requests stop, head held
      for (int c = 0; c < 5; c++) begin
         nxt(0, 0, 0, 0);
         exp_cyc(0, 0, 1, 32'h10);
      end
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h18, 1, 32'h10);
      for (int k = 0; k < 3; k++) begin
         nxt(0, 0, 0, 1);
         exp_cyc(1, 32'h1C + 32'(4 * k), 1, 32'h14 + 32'(4 * k));
      end

      // Aligned redirect with a response in flight
      nxt(0, 1, 32'h40, 1);
      exp_cyc(0, 0, 1, 32'h20);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h40, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h44, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h48, 1, 32'h40);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h4C, 1, 32'h44);

      // Misaligned redirect -> TRAP for 10 cycles
      nxt(0, 1, 32'h42, 1);
      exp_cyc(0, 0, 1, 32'h48);
      exp_trap(0, 0);
      for (int c = 0; c < 10; c++) begin
         nxt(0, 0, 0, 1);
         exp_cyc(0, 0, 0, 0);
         exp_trap(1, 32'h42);
      end
      nxt(0, 1, 32'h46, 1);
      exp_cyc(0, 0, 0, 0);
      exp_trap(1, 32'h42);
      nxt(0, 0, 0, 1);
      exp_cyc(0, 0, 0, 0);
      exp_trap(1, 32'h46);
      nxt(0, 1, 32'h80, 1);
      exp_cyc(0, 0, 0, 0);
      exp_trap(1, 32'h46);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h80, 0, 0);
      chk("misalign clr", {31'b0, fif.misalign}, 32'h0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h84, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h88, 1, 32'h80);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h8C, 1, 32'h84);

      // Fill queue to 2, then redirect while decode pops
      nxt(0, 0, 0, 0);
      exp_cyc(0, 0, 1, 32'h88);
      nxt(0, 1, 32'h200, 1);
      exp_cyc(0, 0, 1, 32'h88);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h200, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h204, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h208, 1, 32'h200);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h20C, 1, 32'h204);

      // Reset together with a redirect: restart at RESET_PC
      nxt(1, 1, 32'h300, 1);
      exp_cyc(0, 0, 1, 32'h208);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h0, 0, 0);
      chk("post-rst dec_pc", fif.dec_pc, 32'h0);
      exp_trap(0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h4, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h8, 1, 32'h0);

      // PC wrap at the top of the address space
      nxt(0, 1, 32'hFFFFFFFC, 1);
      exp_cyc(0, 0, 1, 32'h4);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'hFFFFFFFC, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h0, 0, 0);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h4, 1, 32'hFFFFFFFC);
      nxt(0, 0, 0, 1);
      exp_cyc(1, 32'h8, 1, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
